// File: rtl/sp_ram_master_if.sv
// Request/response bundle between an initiator (LSU/interconnect) and sp_ram_master.
// The slave modport is the controller's view; the master modport is the core's view.
interface sp_ram_master_if #(
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int AW        = 14
);
  logic                        req_i;
  logic                        we_i;
  logic [NB_COL-1:0]           be_i;
  logic [AW+1:0]               addr_i;
  logic [NB_COL*COL_WIDTH-1:0] wdata_i;
  logic                        gnt_o;
  logic                        rvalid_o;
  logic                        rready_i;
  logic [NB_COL*COL_WIDTH-1:0] rdata_o;
  logic                        err_o;

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, rready_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, rready_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/sp_ram_master.sv
// Port controller turning req/gnt/rvalid requests into single-port RAM cycles with a
// credit-limited response FIFO. Define SP_RAM_MASTER_ERR_EN to enable address error checking.
module sp_ram_master #(
  parameter int NB_COL       = 4,
  parameter int COL_WIDTH    = 8,
  parameter int RAM_DEPTH    = 16384,
  parameter int AW           = 14,
  parameter int READ_LATENCY = 1,
  parameter int RSP_DEPTH    = READ_LATENCY + 1
) (
  input  logic                        clka,
  input  logic                        rsta,
  sp_ram_master_if.slave              bus,
  output logic [AW-1:0]               addra,
  output logic [NB_COL*COL_WIDTH-1:0] dina,
  output logic [NB_COL-1:0]           wea,
  output logic                        ena,
  output logic                        regcea,
  output logic                        rsta_ram,
  input  logic [NB_COL*COL_WIDTH-1:0] douta
);

  localparam int DW = NB_COL * COL_WIDTH;
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = CW + 1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RSP_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0] pipe_wr_q, pipe_wr_d;
  logic [READ_LATENCY-1:0] pipe_err_q, pipe_err_d;

  logic [DW-1:0]        fifo_data_q [RSP_DEPTH];
  logic [DW-1:0]        fifo_data_d [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fifo_err_q, fifo_err_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;

  logic          req_err_s;
  logic [OW-1:0] inflight_s;
  logic [OW-1:0] occ_s;
  logic          fifo_empty_s;
  logic          out_vld_s;
  logic [DW-1:0] out_data_s;
  logic          rvalid_s;
  logic [DW-1:0] rdata_s;
  logic          err_s;
  logic          pop_s;
  logic          fifo_pop_s;
  logic          push_s;
  logic          gnt_s;

`ifdef SP_RAM_MASTER_ERR_EN
  assign req_err_s = (bus.addr_i[1:0] != 2'b00) ||
                     (32'(bus.addr_i[AW+1:2]) >= 32'(RAM_DEPTH));
`else
  logic unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^bus.addr_i[1:0];
  assign req_err_s         = 1'b0;
`endif

  // Credit accounting covers both in-flight RAM reads and buffered responses.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_s = inflight_s + OW'(pipe_vld_q[i]);
    end
    occ_s = OW'(fifo_cnt_q) + inflight_s;
  end

  assign fifo_empty_s = (fifo_cnt_q == '0);
  assign out_vld_s    = pipe_vld_q[READ_LATENCY-1];
  assign out_data_s   = (pipe_wr_q[READ_LATENCY-1] || pipe_err_q[READ_LATENCY-1]) ? '0 : douta;

  // Response head: FIFO first, otherwise the pipeline output bypasses an empty FIFO.
  always_comb begin
    rvalid_s = 1'b0;
    rdata_s  = '0;
    err_s    = 1'b0;
    if (rsta) begin
      rvalid_s = 1'b0;
    end else if (!fifo_empty_s) begin
      rvalid_s = 1'b1;
      rdata_s  = fifo_data_q[rd_ptr_q];
      err_s    = fifo_err_q[rd_ptr_q];
    end else if (out_vld_s) begin
      rvalid_s = 1'b1;
      rdata_s  = out_data_s;
      err_s    = pipe_err_q[READ_LATENCY-1];
    end else begin
      rvalid_s = 1'b0;
    end
  end

  assign pop_s      = rvalid_s && bus.rready_i;
  assign fifo_pop_s = pop_s && !fifo_empty_s;
  assign push_s     = out_vld_s && !(fifo_empty_s && pop_s);
  assign gnt_s      = bus.req_i && !rsta && ((occ_s < OW'(RSP_DEPTH)) || pop_s);

  assign bus.gnt_o    = gnt_s;
  assign bus.rvalid_o = rvalid_s;
  assign bus.rdata_o  = rdata_s;
`ifdef SP_RAM_MASTER_ERR_EN
  assign bus.err_o    = err_s;
`else
  assign bus.err_o    = 1'b0;
`endif

  // RAM drive; erroneous requests are granted but never touch the array.
  always_comb begin
    ena = gnt_s && !req_err_s;
    if (ena && bus.we_i) begin
      wea = bus.be_i;
    end else begin
      wea = '0;
    end
  end

  assign addra    = bus.addr_i[AW+1:2];
  assign dina     = bus.wdata_i;
  assign regcea   = 1'b1;
  assign rsta_ram = rsta;

  // In-flight shift register, one stage per cycle of RAM read latency.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_wr_d     = pipe_wr_q;
    pipe_err_d    = pipe_err_q;
    pipe_vld_d[0] = gnt_s;
    pipe_wr_d[0]  = bus.we_i;
    pipe_err_d[0] = req_err_s;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_wr_d[i]  = pipe_wr_q[i-1];
      pipe_err_d[i] = pipe_err_q[i-1];
    end
  end

  // Response FIFO next-state.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_err_d  = fifo_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (push_s) begin
      fifo_data_d[wr_ptr_q] = out_data_s;
      fifo_err_d[wr_ptr_q]  = pipe_err_q[READ_LATENCY-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (fifo_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, fifo_pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // State registers; reset drops everything in flight or buffered.
  always_ff @(posedge clka) begin
    if (rsta) begin
      pipe_vld_q <= '0;
      pipe_wr_q  <= '0;
      pipe_err_q <= '0;
      fifo_err_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_wr_q   <= pipe_wr_d;
      pipe_err_q  <= pipe_err_d;
      fifo_err_q  <= fifo_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_data_q <= fifo_data_d;
    end
  end

endmodule

// File: tb/tb_sp_ram_master.sv
// Scoreboard bench: channel 0 runs READ_LATENCY=1, channel 1 runs READ_LATENCY=2,
// each against a behavioural byte-write RAM with no-change write mode.
module tb_sp_ram_master;

  logic        clk = 1'b0;
  logic        rsta;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        req    [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [15:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        rready [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];
  logic [13:0] addra  [2];
  logic [31:0] dina   [2];
  logic [3:0]  wea    [2];
  logic        ena    [2];
  logic        regcea [2];
  logic        rsta_ram [2];
  logic [31:0] douta  [2];

  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g_ch
    localparam int RL = k + 1;
    logic [31:0] mem [16384];
    logic [31:0] dout1;
    logic [31:0] dout2;

    sp_ram_master_if #(.NB_COL(4), .COL_WIDTH(8), .AW(14)) bus ();

    assign bus.req_i    = req[k];
    assign bus.we_i     = we[k];
    assign bus.be_i     = be[k];
    assign bus.addr_i   = addr[k];
    assign bus.wdata_i  = wdata[k];
    assign bus.rready_i = rready[k];
    assign gnt[k]       = bus.gnt_o;
    assign rvalid[k]    = bus.rvalid_o;
    assign rdata[k]     = bus.rdata_o;
    assign err[k]       = bus.err_o;

    sp_ram_master #(
      .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(16384), .AW(14), .READ_LATENCY(RL)
    ) u_dut (
      .clka(clk), .rsta(rsta), .bus(bus),
      .addra(addra[k]), .dina(dina[k]), .wea(wea[k]), .ena(ena[k]),
      .regcea(regcea[k]), .rsta_ram(rsta_ram[k]), .douta(douta[k])
    );

    always @(posedge clk) begin
      if (ena[k]) begin
        if (wea[k] != 4'h0) begin
          for (int b = 0; b < 4; b++) begin
            if (wea[k][b]) mem[addra[k]][8*b +: 8] <= dina[k][8*b +: 8];
          end
        end else begin
          dout1 <= mem[addra[k]];
        end
      end
      if (rsta_ram[k]) dout2 <= 32'h0;
      else if (regcea[k]) dout2 <= dout1;
    end

    assign douta[k] = (RL == 1) ? dout1 : dout2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int k, input logic [32:0] v);
    if (k == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  task automatic check_pop(input int k);
    logic [32:0] e;
    int          sz;
    sz = (k == 0) ? exp_q0.size() : exp_q1.size();
    checks++;
    if (sz == 0) begin
      errors++;
      $display("FAIL rsp_unexpected ch%0d: got err=%0b data=%h, required no response",
               k, err[k], rdata[k]);
    end else begin
      if (k == 0) e = exp_q0.pop_front();
      else e = exp_q1.pop_front();
      if ({err[k], rdata[k]} !== e) begin
        errors++;
        $display("FAIL rsp ch%0d: got err=%0b data=%h, required err=%0b data=%h",
                 k, err[k], rdata[k], e[32], e[31:0]);
      end
    end
  endtask

  // Monitor: every accepted response is compared against the scoreboard head.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rvalid[k] && rready[k]) check_pop(k);
    end
  end

  task automatic issue(input int k, input logic w, input logic [3:0] b, input logic [15:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                       output int gc);
    int n;
    bit done;
    gc = -1;
    n = 0;
    done = 1'b0;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
    while (!done) begin
      @(negedge clk);
      if (gnt[k]) begin
        done = 1'b1;
        gc = cyc;
        push_exp(k, {exp_e, exp_d});
        chk("ena", 32'(ena[k]), exp_e ? 32'h0 : 32'h1);
        chk("wea", 32'(wea[k]), (w && !exp_e) ? 32'(b) : 32'h0);
        chk("addra", 32'(addra[k]), 32'(a[15:2]));
      end else if (n >= 50) begin
        done = 1'b1;
        checks++;
        errors++;
        $display("FAIL gnt_timeout ch%0d: got no grant in 50 cycles, required a grant", k);
      end else begin
        n++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int k);
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    idle(k);
    n = 0;
    while (((k == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (((k == 0) ? exp_q0.size() : exp_q1.size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout ch%0d: got %0d pending, required 0", k,
               (k == 0) ? exp_q0.size() : exp_q1.size());
    end
  endtask

  initial begin
    int g, g_first, ng;
    logic [31:0] bp_exp [6];
    bp_exp = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4, 32'h0, 32'h0};
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 16'h0; wdata[k] = 32'h0;
      rready[k] = 1'b1;
    end
    rsta = 1'b1;
    repeat (3) @(posedge clk);
    #1 req[0] = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt[0]), 32'h0);
    chk("rst_ena", 32'(ena[0]), 32'h0);
    chk("rst_wea", 32'(wea[0]), 32'h0);
    chk("rst_rvalid", 32'(rvalid[0]), 32'h0);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_err", 32'(err[0]), 32'h0);
    chk("regcea", 32'(regcea[0]), 32'h1);
    chk("rsta_ram", 32'(rsta_ram[1]), 32'h1);
    @(posedge clk); #1;
    req[0] = 1'b0; rsta = 1'b0;

    // Write then read, latency 1.
    issue(0, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, g);
    issue(0, 1'b0, 4'h0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, g);
    chk("wr_rsp_valid", 32'(rvalid[0]), 32'h1);
    chk("wr_rsp_rdata", rdata[0], 32'h0);
    idle(0);
    @(negedge clk);
    chk("rl1_lat_valid", 32'(rvalid[0]), 32'h1);
    chk("rl1_lat_rdata", rdata[0], 32'hDEADBEEF);
    drain(0);

    // Byte enables.
    issue(0, 1'b1, 4'hF, 16'h0020, 32'hAABBCCDD, 32'h0, 1'b0, g);
    issue(0, 1'b1, 4'h5, 16'h0020, 32'h11223344, 32'h0, 1'b0, g);
    issue(0, 1'b0, 4'h0, 16'h0020, 32'h0, 32'hAA22CC44, 1'b0, g);
    drain(0);

    // Eight writes then eight back-to-back reads.
    for (int i = 0; i < 8; i++)
      issue(0, 1'b1, 4'hF, 16'h0100 + 16'(4 * i), 32'hC0DE0000 + 32'(i), 32'h0, 1'b0, g);
    g_first = -1;
    for (int i = 0; i < 8; i++) begin
      issue(0, 1'b0, 4'h0, 16'h0100 + 16'(4 * i), 32'h0, 32'hC0DE0000 + 32'(i), 1'b0, g);
      if (i == 0) g_first = g;
      chk("b2b_no_bubble", 32'(rvalid[0]), 32'h1);
    end
    chk("b2b_grant_span", 32'(g - g_first), 32'd7);
    idle(0);
    @(negedge clk);
    chk("b2b_last_valid", 32'(rvalid[0]), 32'h1);
    drain(0);

`ifdef SP_RAM_MASTER_ERR_EN
    issue(0, 1'b0, 4'h0, 16'h0013, 32'h0, 32'h0, 1'b1, g);
    issue(0, 1'b1, 4'hF, 16'h0012, 32'h55555555, 32'h0, 1'b1, g);
    drain(0);
    issue(0, 1'b0, 4'h0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, g);
    drain(0);
`endif

    // Latency-2 channel: preload, then check read latency.
    for (int i = 0; i < 4; i++)
      issue(1, 1'b1, 4'hF, 16'h0040 + 16'(4 * i), bp_exp[i], 32'h0, 1'b0, g);
    drain(1);
    issue(1, 1'b0, 4'h0, 16'h0040, 32'h0, 32'hA1A1A1A1, 1'b0, g);
    idle(1);
    @(negedge clk);
    chk("rl2_lat_early", 32'(rvalid[1]), 32'h0);
    @(negedge clk);
    chk("rl2_lat_valid", 32'(rvalid[1]), 32'h1);
    drain(1);

    // Backpressure: rready low, request held for 6 cycles.
    @(posedge clk); #1 rready[1] = 1'b0;
    ng = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0040 + 16'(4 * ng);
      @(negedge clk);
      if (gnt[1] && ng < 6) begin
        push_exp(1, {1'b0, bp_exp[ng]});
        ng++;
      end
    end
    chk("bp_grants", 32'(ng), 32'd3);
    chk("bp_gnt_low", 32'(gnt[1]), 32'h0);
    @(posedge clk); #1;
    rready[1] = 1'b1; addr[1] = 16'h0040 + 16'(4 * ng);
    @(negedge clk);
    chk("bp_resume_gnt", 32'(gnt[1]), 32'h1);
    chk("bp_resume_pop", 32'(rvalid[1]), 32'h1);
    if (gnt[1] && ng < 6) push_exp(1, {1'b0, bp_exp[ng]});
    drain(1);

    // Reset with two reads in flight.
    issue(1, 1'b0, 4'h0, 16'h0040, 32'h0, 32'hA1A1A1A1, 1'b0, g);
    issue(1, 1'b0, 4'h0, 16'h0044, 32'h0, 32'hB2B2B2B2, 1'b0, g);
    @(posedge clk); #1;
    req[1] = 1'b0; rsta = 1'b1;
    @(negedge clk);
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk); #1 rsta = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(rvalid[1]), 32'h0);
    end
    issue(1, 1'b0, 4'h0, 16'h0048, 32'h0, 32'hC3C3C3C3, 1'b0, g);
    drain(1);
    issue(0, 1'b0, 4'h0, 16'h0020, 32'h0, 32'hAA22CC44, 1'b0, g);
    drain(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $fatal(1, "watchdog");
  end

endmodule
